// File: rtl/one_wire_pkg.sv
// Shared definitions for the 1-Wire slave receiver.
// State encoding, microsecond-to-cycle conversion, CRC-8 polynomial.
package one_wire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RST,
        ST_RST_LOW,
        ST_PD_WAIT,
        ST_PD_PULSE,
        ST_SLOT_WAIT,
        ST_SLOT_SAMPLE,
        ST_SLOT_END
    } ow_state_e;

    // Dallas CRC-8, x^8+x^5+x^4+1. Bits arrive LSB first, so the
    // serial engine shifts right and uses the bit-reversed form.
    localparam logic [7:0] CRC8_POLY      = 8'h31;
    localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

    function automatic logic [31:0] us2cyc(
        input int unsigned us,
        input int unsigned mhz
    );
        return 32'(us * mhz);
    endfunction

endpackage

// File: rtl/one_wire_slave_rx_if.sv
// Received-byte stream from the 1-Wire slave receiver.
// master: receiver side (drives); slave: consumer side.
interface one_wire_slave_rx_if #(
    parameter int CW = 4
);
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [CW-1:0] byte_idx;
    logic          overflow;
`ifdef ONE_WIRE_RX_CRC_EN
    logic          crc_ok;
`endif

    modport master (
        output rx_valid,
        output rx_byte,
        output byte_idx,
        output overflow
`ifdef ONE_WIRE_RX_CRC_EN
        ,
        output crc_ok
`endif
    );

    modport slave (
        input rx_valid,
        input rx_byte,
        input byte_idx,
        input overflow
`ifdef ONE_WIRE_RX_CRC_EN
        ,
        input crc_ok
`endif
    );
endinterface

// File: rtl/one_wire_crc8.sv
// Serial Dallas CRC-8, one bit per enabled cycle, init 0.
// Ports: clk, rst_n, clr_i (sync clear), en_i, bit_i, crc_o.
module one_wire_crc8
    import one_wire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[0] ^ bit_i;
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (fb ? CRC8_POLY_REFL : 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/one_wire_slave_rx.sv
// 1-Wire slave receiver: reset/presence detection and byte reception.
// Ports: clk, rst_n, enable, ow_in, ow_pull_low, presence, reset_seen,
// rx (rx_valid/rx_byte/byte_idx/overflow[/crc_ok]).
// Macro ONE_WIRE_RX_CRC_EN adds the serial CRC-8 and crc_ok.
module one_wire_slave_rx
    import one_wire_pkg::*;
#(
    parameter int CLK_MHZ   = 100,
    parameter int T_RSTL_US = 480,
    parameter int T_PDH_US  = 30,
    parameter int T_PDL_US  = 120,
    parameter int T_SAMP_US = 30,
    parameter int MAX_BYTES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 ow_in,
    output logic                 ow_pull_low,
    output logic                 presence,
    output logic                 reset_seen,
    one_wire_slave_rx_if.master  rx
);

    localparam int CW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [31:0] T_RSTL = us2cyc(T_RSTL_US, CLK_MHZ);
    localparam logic [31:0] T_PDH  = us2cyc(T_PDH_US, CLK_MHZ);
    localparam logic [31:0] T_PDL  = us2cyc(T_PDL_US, CLK_MHZ);
    localparam logic [31:0] T_SAMP = us2cyc(T_SAMP_US, CLK_MHZ);
    localparam logic [31:0] MAXB   = 32'(MAX_BYTES);
    localparam logic [31:0] SAT    = 32'hFFFF_FFFF;

    logic          sync1_q, sync2_q, prev_q;
    logic [31:0]   low_cnt_q, low_cnt_d;
    ow_state_e     state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   bit_cnt_q, bit_cnt_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [CW-1:0] byte_idx_q, byte_idx_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overflow_q, overflow_d;
    logic          reset_seen_q, reset_seen_d;
    logic          presence_q, presence_d;

    logic          ow_s;
    logic          fall;
    logic          in_slot;
    logic          slot_rst;
    logic          samp;
    logic          byte_end;
    logic          pd_enter;

    assign ow_s = sync2_q;
    assign fall = prev_q & ~sync2_q;

    assign in_slot = (state_q == ST_SLOT_WAIT)
                   | (state_q == ST_SLOT_SAMPLE)
                   | (state_q == ST_SLOT_END);

    // A long low inside the slot phase is a fresh bus reset.
    assign slot_rst = in_slot & (low_cnt_q >= T_RSTL);

    assign samp = (state_q == ST_SLOT_SAMPLE) & ~slot_rst
                & (cnt_q + 32'd1 >= T_SAMP);

    assign byte_end = samp & (bit_cnt_q >= 32'd7);

    always_comb begin
        low_cnt_d = sync2_q ? 32'd0
                  : ((low_cnt_q == SAT) ? low_cnt_q : low_cnt_q + 32'd1);

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_idx_d   = byte_idx_q;
        rx_valid_d   = 1'b0;
        overflow_d   = overflow_q;
        reset_seen_d = 1'b0;
        pd_enter     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_RST;
            end
            ST_WAIT_RST: begin
                if (!ow_s) state_d = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                if (ow_s) begin
                    if (low_cnt_q >= T_RSTL) begin
                        state_d      = ST_PD_WAIT;
                        reset_seen_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RST;
                    end
                end
            end
            ST_PD_WAIT: begin
                if (cnt_q + 32'd1 >= T_PDH) begin
                    state_d  = ST_PD_PULSE;
                    pd_enter = 1'b1;
                end
            end
            ST_PD_PULSE: begin
                if (cnt_q + 32'd1 >= T_PDL) state_d = ST_SLOT_WAIT;
            end
            ST_SLOT_WAIT: begin
                if (fall) state_d = ST_SLOT_SAMPLE;
            end
            ST_SLOT_SAMPLE: begin
                if (samp) state_d = ST_SLOT_END;
            end
            ST_SLOT_END: begin
                if (ow_s) state_d = ST_SLOT_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (samp) begin
            shift_d   = {ow_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 32'd1;
        end

        if (byte_end) begin
            bit_cnt_d = 32'd0;
            if (byte_cnt_q >= MAXB) begin
                overflow_d = 1'b1;
            end else begin
                rx_valid_d = 1'b1;
                rx_byte_d  = shift_d;
                byte_idx_d = byte_cnt_q[CW-1:0];
                byte_cnt_d = byte_cnt_q + 32'd1;
            end
        end

        if (slot_rst) begin
            state_d   = ST_RST_LOW;
            bit_cnt_d = 32'd0;
            shift_d   = 8'h00;
        end

        if (pd_enter) begin
            byte_cnt_d = 32'd0;
            overflow_d = 1'b0;
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            reset_seen_d = 1'b0;
        end

        // Timer restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + 32'd1;
        end

        presence_d = (state_d == ST_PD_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            low_cnt_q    <= 32'd0;
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            bit_cnt_q    <= 32'd0;
            byte_cnt_q   <= 32'd0;
            shift_q      <= 8'h00;
            rx_byte_q    <= 8'h00;
            byte_idx_q   <= '0;
            rx_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            reset_seen_q <= 1'b0;
            presence_q   <= 1'b0;
        end else begin
            sync1_q      <= ow_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            low_cnt_q    <= low_cnt_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_idx_q   <= byte_idx_d;
            rx_valid_q   <= rx_valid_d;
            overflow_q   <= overflow_d;
            reset_seen_q <= reset_seen_d;
            presence_q   <= presence_d;
        end
    end

    // Dropping enable must free the bus without waiting for a clock.
    assign ow_pull_low = presence_q & enable;
    assign presence    = presence_q & enable;
    assign reset_seen  = reset_seen_q;

    assign rx.rx_valid = rx_valid_q;
    assign rx.rx_byte  = rx_byte_q;
    assign rx.byte_idx = byte_idx_q;
    assign rx.overflow = overflow_q;

`ifdef ONE_WIRE_RX_CRC_EN
    logic [7:0] crc_val;
    logic       byte_done_q;
    logic       crc_ok_q, crc_ok_d;

    one_wire_crc8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (pd_enter),
        .en_i  (samp),
        .bit_i (ow_s),
        .crc_o (crc_val)
    );

    // crc_val already includes the eighth bit one cycle after byte_end.
    always_comb begin
        crc_ok_d = crc_ok_q;
        if (pd_enter) begin
            crc_ok_d = 1'b0;
        end else if (byte_done_q) begin
            crc_ok_d = (crc_val == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_done_q <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else begin
            byte_done_q <= byte_end;
            crc_ok_q    <= crc_ok_d;
        end
    end

    assign rx.crc_ok = crc_ok_q;
`endif

endmodule
